hp_div: RTL

- Iterative IEEE 754 half-precision divider, q = a / b. It is the inverse operation of the team's combinational half-precision multiplier.
- Used by the DNN datapath for normalization and scaling, where a multi-cycle divide is acceptable.
- Operands enter on a valid/ready handshake. A radix-2 restoring divider produces the quotient significand. The result leaves on a valid/ready handshake together with the same six class flags the multiplier produces.

---
 rtl/hp_pkg.sv | 33 +++
 rtl/hp_class.sv | 66 ++++++
 rtl/hp_div.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hp_pkg.sv
// Shared half-precision definitions for the hp_* arithmetic blocks.
//   - format constants (exponent bias and unbiased exponent limits)
//   - canonical special-value patterns
//   - result class flag struct (one-hot when a result is valid)
//   - divider state encoding
package hp_pkg;

    localparam int EXP_BIAS = 15;
    localparam int EMIN     = -14;   // smallest normal exponent
    localparam int EMIN_SUB = -24;   // exponent of the smallest subnormal
    localparam int EMAX     = 15;    // largest normal exponent

    localparam logic [8:0]  QNAN_PAYLOAD = 9'h02A;
    localparam logic [15:0] POS_INF      = 16'h7C00;

    // Class flags, ordered as they appear on the block outputs.
    typedef struct packed {
        logic snan;
        logic qnan;
        logic infinity;
        logic zero;
        logic subnormal;
        logic normal;
    } hp_flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/hp_class.sv
// Combinational fp16 operand unpacker.
//   x    : fp16 operand
//   sign : sign bit
//   exp  : unbiased exponent, -24..15 for finite nonzero values
//          (0 for zero, inf and NaN)
//   sig  : 11-bit significand, leading 1 at bit 10 for finite nonzero values;
//          subnormals are pre-normalized so the leading 1 is moved up to bit 10
//   cls  : one-hot class of x
module hp_class
    import hp_pkg::*;
(
    input  logic [15:0]       x,
    output logic              sign,
    output logic signed [6:0] exp,
    output logic [10:0]       sig,
    output hp_flags_t         cls
);

    logic [4:0] exp_field;
    logic [9:0] man;
    logic [3:0] lead;   // bit position of the leading 1 in the mantissa

    assign sign      = x[15];
    assign exp_field = x[14:10];
    assign man       = x[9:0];

    always_comb begin
        lead = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (man[i]) begin
                lead = 4'(i);
            end
        end
    end

    always_comb begin
        exp = 7'sd0;
        sig = 11'd0;
        cls = '0;
        if (exp_field == 5'd0) begin
            if (man == 10'd0) begin
                cls.zero = 1'b1;
            end else begin
                // Shift the leading 1 up to bit 10; each shift costs one
                // exponent step below EMIN.
                cls.subnormal = 1'b1;
                sig = {1'b0, man} << (4'd10 - lead);
                exp = $signed({3'b000, lead}) - 7'sd24;
            end
        end else if (exp_field == 5'h1F) begin
            sig = {1'b1, man};
            if (man == 10'd0) begin
                cls.infinity = 1'b1;
            end else if (man[9]) begin
                cls.qnan = 1'b1;
            end else begin
                cls.snan = 1'b1;
            end
        end else begin
            cls.normal = 1'b1;
            sig = {1'b1, man};
            exp = $signed({2'b00, exp_field}) - 7'sd15;
        end
    end

endmodule

// File: rtl/hp_div.sv
// Iterative fp16 divider, q = a / b, radix-2 restoring, truncating.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : operand pair valid
//   in_ready   : high while idle; an operand pair is taken on a clock edge
//                with in_valid & in_ready
//   a, b       : dividend, divisor (fp16)
//   out_valid  : result valid; q and flags hold until out_valid & out_ready
//   out_ready  : consumer takes the result on a clock edge with
//                out_valid & out_ready
//   q          : quotient (fp16)
//   snan..normal : one-hot class of q while out_valid is high
//
// Handshake: both sides are plain valid/ready. A transfer happens on a
// rising edge where valid and ready are both high; the source must hold its
// data stable until then. Only one operation is in flight: in_ready stays
// low from accept until the result has been handed off.
//
// Special operands are resolved at accept and appear the next cycle.
// Ordinary operands take 14 cycles: one cycle to set up the working
// registers from the captured operands, ITERS quotient-bit cycles, one
// normalize/pack cycle.
module hp_div
    import hp_pkg::*;
#(
    parameter int ITERS = 12
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q,
    output logic        snan,
    output logic        qnan,
    output logic        infinity,
    output logic        zero,
    output logic        subnormal,
    output logic        normal
);

    localparam logic [3:0]        LAST_STEP  = 4'(ITERS);
    localparam logic signed [7:0] EMAX_S     = 8'(EMAX);
    localparam logic signed [7:0] EMIN_S     = 8'(EMIN);
    localparam logic signed [7:0] EMIN_SUB_S = 8'(EMIN_SUB);
    localparam logic signed [7:0] BIAS_S     = 8'(EXP_BIAS);

    // Operand decode
    logic              a_sign, b_sign;
    logic signed [6:0] a_exp,  b_exp;
    logic [10:0]       a_sig,  b_sig;
    hp_flags_t         a_cls,  b_cls;

    hp_class u_a_class (
        .x    (a),
        .sign (a_sign),
        .exp  (a_exp),
        .sig  (a_sig),
        .cls  (a_cls)
    );

    hp_class u_b_class (
        .x    (b),
        .sign (b_sign),
        .exp  (b_exp),
        .sig  (b_sig),
        .cls  (b_cls)
    );

    // State
    div_state_e        state_q,     state_d;
    logic [3:0]        step_q,      step_d;      // 0 = setup, 1..ITERS = bits
    logic              sign_q,      sign_d;
    logic [10:0]       a_sig_q,     a_sig_d;
    logic [10:0]       b_sig_q,     b_sig_d;
    logic signed [6:0] e_q,         e_d;
    logic [11:0]       rem_q,       rem_d;
    logic [11:0]       quo_q,       quo_d;
    logic [15:0]       q_q,         q_d;
    hp_flags_t         flags_q,     flags_d;
    logic              out_valid_q, out_valid_d;

    // Quotient-bit step
    logic [11:0] diff;
    logic        take;

    assign take = (rem_q >= {1'b0, b_sig_q});
    assign diff = rem_q - {1'b0, b_sig_q};

    // Normalize / pack of the finished quotient
    logic [10:0]       n_sig;
    logic signed [7:0] n_exp;
    logic [3:0]        n_shamt;
    logic [9:0]        n_sub_man;
    logic [4:0]        n_biased;

    always_comb begin
        // The quotient of two significands in [1,2) lies in (1/2,2), so
        // Q[11] or Q[10] is always set.
        if (quo_q[11]) begin
            n_sig = quo_q[11:1];
            n_exp = 8'(e_q);
        end else begin
            n_sig = quo_q[10:0];
            n_exp = 8'(e_q) - 8'sd1;
        end
        // Only meaningful for exponents in EMIN_SUB..EMIN-1 (shift 1..10).
        n_shamt   = 4'(EMIN_S - n_exp);
        n_sub_man = 10'(n_sig >> n_shamt);
        n_biased  = 5'(n_exp + BIAS_S);
    end

    // Next state
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        sign_d      = sign_q;
        a_sig_d     = a_sig_q;
        b_sig_d     = b_sig_q;
        e_d         = e_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        q_d         = q_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = a_sign ^ b_sign;
                    flags_d = '0;
                    if (a_cls.snan || b_cls.snan) begin
                        q_d          = a_cls.snan ? a : b;
                        flags_d.snan = 1'b1;
                        state_d      = DONE;
                        out_valid_d  = 1'b1;
                    end else if (a_cls.qnan || b_cls.qnan) begin
                        q_d          = a_cls.qnan ? a : b;
                        flags_d.qnan = 1'b1;
                        state_d      = DONE;
                        out_valid_d  = 1'b1;
                    end else if ((a_cls.infinity && b_cls.infinity) ||
                                 (a_cls.zero && b_cls.zero)) begin
                        q_d          = {a_sign ^ b_sign, 5'h1F, 1'b1, QNAN_PAYLOAD};
                        flags_d.qnan = 1'b1;
                        state_d      = DONE;
                        out_valid_d  = 1'b1;
                    end else if (a_cls.infinity || b_cls.zero) begin
                        q_d              = {a_sign ^ b_sign, POS_INF[14:0]};
                        flags_d.infinity = 1'b1;
                        state_d          = DONE;
                        out_valid_d      = 1'b1;
                    end else if (a_cls.zero || b_cls.infinity) begin
                        q_d          = {a_sign ^ b_sign, 15'd0};
                        flags_d.zero = 1'b1;
                        state_d      = DONE;
                        out_valid_d  = 1'b1;
                    end else if ((a_cls.normal || a_cls.subnormal) &&
                                 (b_cls.normal || b_cls.subnormal)) begin
                        a_sig_d = a_sig;
                        b_sig_d = b_sig;
                        e_d     = a_exp - b_exp;
                        step_d  = 4'd0;
                        state_d = DIV;
                    end
                end
            end

            DIV: begin
                step_d = step_q + 4'd1;
                if (step_q == 4'd0) begin
                    rem_d = {1'b0, a_sig_q};
                    quo_d = 12'd0;
                end else begin
                    // The remainder stays below D < 2^11 after each step, so
                    // dropping bit 11 before the shift loses nothing.
                    if (take) begin
                        rem_d = {diff[10:0], 1'b0};
                        quo_d = {quo_q[10:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[10:0], 1'b0};
                        quo_d = {quo_q[10:0], 1'b0};
                    end
                    if (step_q == LAST_STEP) begin
                        state_d = NORM;
                    end
                end
            end

            NORM: begin
                flags_d = '0;
                if (n_exp > EMAX_S) begin
                    q_d              = {sign_q, POS_INF[14:0]};
                    flags_d.infinity = 1'b1;
                end else if (n_exp < EMIN_SUB_S) begin
                    q_d          = {sign_q, 15'd0};
                    flags_d.zero = 1'b1;
                end else if (n_exp < EMIN_S) begin
                    q_d               = {sign_q, 5'd0, n_sub_man};
                    flags_d.subnormal = 1'b1;
                end else begin
                    q_d            = {sign_q, n_biased, n_sig[9:0]};
                    flags_d.normal = 1'b1;
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= 4'd0;
            sign_q      <= 1'b0;
            a_sig_q     <= 11'd0;
            b_sig_q     <= 11'd0;
            e_q         <= 7'sd0;
            rem_q       <= 12'd0;
            quo_q       <= 12'd0;
            q_q         <= 16'd0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            sign_q      <= sign_d;
            a_sig_q     <= a_sig_d;
            b_sig_q     <= b_sig_d;
            e_q         <= e_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            q_q         <= q_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign snan      = flags_q.snan;
    assign qnan      = flags_q.qnan;
    assign infinity  = flags_q.infinity;
    assign zero      = flags_q.zero;
    assign subnormal = flags_q.subnormal;
    assign normal    = flags_q.normal;

endmodule
